// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and defaults for the I2S receive path
// Contents: rx_state_e (receiver FSM states), chan_e (channel encoding),
//           I2S_DEFAULT_BIT_DEPTH (default word width).
package i2s_pkg;

  localparam int I2S_DEFAULT_BIT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - synchronous FIFO holding completed I2S words
// Ports: clk, reset (async, active-high); push/push_data write side;
//        pop read side; full, empty status; drop = push refused while full;
//        head = word at the read pointer.
module i2s_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: bclk/lrclk/sdata to a valid/ready sample stream
// Ports: clk, reset (async, active-high); bclk, lrclk, sdata (async serial in);
//        out_valid/out_ready/out_data/out_right (sample stream);
//        overflow (sticky drop flag), clear (sync pulse, clears overflow);
//        frame_err (one-cycle pulse on a short word).
// Optional: define I2S_RX_ERR_CNT_EN to add err_count[15:0], a saturating
//           count of frame errors and dropped words.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int BIT_DEPTH  = I2S_DEFAULT_BIT_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 sdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] out_data,
  output logic                 out_right,
  output logic                 overflow,
  input  logic                 clear,
`ifdef I2S_RX_ERR_CNT_EN
  output logic [15:0]          err_count,
`endif
  output logic                 frame_err
);

  localparam int CW = $clog2(BIT_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(BIT_DEPTH - 1);

  logic bclk_m, bclk_s, bclk_d;
  logic lr_m, lr_s, lr_prev;
  logic sd_m, sd_s;
  logic bclk_rise, ws_edge;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BIT_DEPTH-2:0] shreg_q, shreg_d;
  chan_e                chan_q, chan_d;
  logic                 push_d, ferr_d;
  logic                 push_q;
  logic [BIT_DEPTH:0]   push_data_q;

  logic                 fifo_full, fifo_empty, fifo_drop;
  logic [BIT_DEPTH:0]   fifo_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {bclk_m, bclk_s, bclk_d} <= 3'b000;
      {lr_m, lr_s, sd_m, sd_s} <= 4'b0000;
      lr_prev                  <= 1'b0;
    end else begin
      bclk_m <= bclk;
      bclk_s <= bclk_m;
      bclk_d <= bclk_s;
      lr_m   <= lrclk;
      lr_s   <= lr_m;
      sd_m   <= sdata;
      sd_s   <= sd_m;
      if (bclk_rise) lr_prev <= lr_s;
    end
  end

  assign bclk_rise = bclk_s && !bclk_d;
  assign ws_edge   = lr_s ^ lr_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      chan_q      <= CH_LEFT;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      chan_q    <= chan_d;
      push_q    <= push_d;
      frame_err <= ferr_d;
      // The last bit is taken straight from sd_s; shreg only holds the earlier ones.
      if (push_d) push_data_q <= {chan_q, shreg_q, sd_s};
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    chan_d    = chan_q;
    push_d    = 1'b0;
    ferr_d    = 1'b0;
    if (bclk_rise) begin
      case (state_q)
        IDLE: begin
          if (ws_edge) state_d = DELAY;
        end
        DELAY: begin
          if (ws_edge) begin
            ferr_d = 1'b1;
          end else begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            chan_d    = chan_e'(lr_s);
          end
        end
        SHIFT: begin
          if (ws_edge) begin
            ferr_d  = 1'b1;
            state_d = DELAY;
          end else begin
            shreg_d   = {shreg_q[BIT_DEPTH-3:0], sd_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              push_d  = 1'b1;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (ws_edge) state_d = DELAY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  i2s_rx_fifo #(
    .WIDTH (BIT_DEPTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (out_valid && out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .head      (fifo_head)
  );

  // Unwritten FIFO memory is never exposed: outputs read zero while empty.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head[BIT_DEPTH-1:0] : '0;
  assign out_right = out_valid && fifo_head[BIT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (clear)     overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_count} + {15'd0, frame_err} + {15'd0, fifo_drop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      err_count <= '0;
    else if (clear) err_count <= '0;
    else            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench for i2s_rx
module tb_i2s_rx;

  localparam int BD = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bclk, lrclk, sdata;
  logic          out_valid, out_ready, out_right;
  logic [BD-1:0] out_data;
  logic          overflow, clear, frame_err;
`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0]   err_count;
`endif

  int total = 0;
  int bad   = 0;
  int ferr_seen = 0;
  int ferr_exp  = 0;
  logic [BD:0] exp_q [$];

  always #5 clk = ~clk;

  i2s_rx #(.BIT_DEPTH(BD), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_right (out_right),
    .overflow  (overflow),
    .clear     (clear),
`ifdef I2S_RX_ERR_CNT_EN
    .err_count (err_count),
`endif
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output word.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_seen++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got right=%0b data=%h expected none", out_right, out_data);
      end else begin
        check("sample", {23'd0, out_right, out_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic lr, input logic b);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = b;
    #40;
    bclk  = 1'b1;
    #40;
  endtask

  // One slot: lrclk-change bit, I2S delay bit, then n data bits MSB first.
  task automatic send_word(input logic lr, input logic [31:0] val, input int n);
    send_bit(lr, 1'b0);
    send_bit(lr, 1'b0);
    for (int i = n - 1; i >= 0; i--) send_bit(lr, val[i]);
  endtask

  task automatic expect_word(input logic right, input logic [BD-1:0] data);
    exp_q.push_back({right, data});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clear;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    out_ready = 1'b1; clear = 1'b0;
    #25;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_right", out_right, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    #5 reset = 1'b0;

    // Basic stream; the first left word has no preceding ws edge and is ignored.
    send_word(1'b0, 32'h77, 8);
    expect_word(1'b1, 8'h3C); send_word(1'b1, 32'h3C, 8);
    expect_word(1'b0, 8'hA5); send_word(1'b0, 32'hA5, 8);
    expect_word(1'b1, 8'h3C); send_word(1'b1, 32'h3C, 8);
    wait_drain("drain_basic");
    check("ferr_basic", ferr_seen, ferr_exp);

    // Short word: lrclk flips after 5 data bits.
    send_word(1'b0, 32'h15, 5);
    ferr_exp++;
    expect_word(1'b1, 8'h96); send_word(1'b1, 32'h96, 8);
    wait_drain("drain_short");
    check("ferr_short", ferr_seen, ferr_exp);

    // Over-long word: trailing bits ignored.
    expect_word(1'b0, 8'hF0); send_word(1'b0, 32'hF0F, 12);
    expect_word(1'b1, 8'h5A); send_word(1'b1, 32'h5A, 8);
    wait_drain("drain_long");

    // Overflow: 6 words with the consumer stalled; the first 4 are kept.
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= FD) expect_word(logic'(i % 2 == 0), 8'(i));
      send_word(logic'(i % 2 == 0), 32'(i), 8);
    end
    repeat (10) @(negedge clk);
    check("ovf_set", overflow, 1);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, 8'h01);
    check("hold_right", out_right, 0);
    out_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", overflow, 1);
    pulse_clear;
    check("ovf_clear", overflow, 0);

    // Reset in the middle of a right word.
    expect_word(1'b0, 8'hC3); send_word(1'b0, 32'hC3, 8);
    wait_drain("drain_pre_reset");
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
    reset = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    #20;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_right", out_right, 0);
    check("mid_rst_frame_err", frame_err, 0);
    #20 reset = 1'b0;
    send_word(1'b0, 32'h44, 8);
    expect_word(1'b1, 8'h88); send_word(1'b1, 32'h88, 8);
    wait_drain("drain_post_reset");
`ifdef I2S_RX_ERR_CNT_EN
    check("errcnt_after_reset", err_count, 0);
`endif

    // Three short words then one dropped word.
    send_word(1'b0, 32'h5, 3);
    send_word(1'b1, 32'h5, 3);
    send_word(1'b0, 32'h5, 3);
    ferr_exp += 3;
    expect_word(1'b1, 8'h11); send_word(1'b1, 32'h11, 8);
    wait_drain("drain_err");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < FD) expect_word(logic'(i % 2), 8'h20 + 8'(i));
      send_word(logic'(i % 2), 32'h20 + 32'(i), 8);
    end
    repeat (10) @(negedge clk);
    check("ovf_set2", overflow, 1);
`ifdef I2S_RX_ERR_CNT_EN
    check("errcnt_four", err_count, 4);
`endif
    out_ready = 1'b1;
    wait_drain("drain_err_ovf");
    pulse_clear;
    check("ovf_clear2", overflow, 0);
`ifdef I2S_RX_ERR_CNT_EN
    check("errcnt_clear", err_count, 0);
`endif
    check("ferr_total", ferr_seen, ferr_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
